// File: rtl/a25_wishbone_arb.sv
// ---------------------------------------------------------------------------
// a25_wishbone_arb
//
// Arbiter and cycle sequencer for the Amber core's 128-bit wishbone master.
// It picks one of three buffered request ports, runs a single classic
// (non-pipelined) wishbone cycle for it, and returns read data to that port.
//
// Ports:
//   i_clk, i_rst            clock; asynchronous active-high reset
//   i_port_valid[2:0]       request valid (0 = icache, 1 = dcache cached,
//                           2 = dcache uncached)
//   o_port_accepted[2:0]    one-hot pulse in the cycle a request is captured
//   i_port_write/wdata/be/addr  per-port request fields, port n packed at n
//   o_port_rdata            shared read data, qualified by o_port_rdata_valid
//   o_port_rdata_valid[2:0] one-hot pulse the cycle after a read completes
//   o_wb_*                  wishbone master outputs (stb mirrors cyc)
//   i_wb_dat/ack/err        wishbone slave responses
//
// Build option:
//   A25_WB_ARB_RR_EN  defined   -> round-robin arbitration
//                     undefined -> fixed priority, port 0 > 1 > 2
// ---------------------------------------------------------------------------
module a25_wishbone_arb #(
    parameter int WB_DWIDTH = 128,
    parameter int WB_SWIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [2:0]             i_port_valid,
    output logic [2:0]             o_port_accepted,
    input  logic [2:0]             i_port_write,
    input  logic [3*WB_DWIDTH-1:0] i_port_wdata,
    input  logic [3*WB_SWIDTH-1:0] i_port_be,
    input  logic [3*32-1:0]        i_port_addr,
    output logic [WB_DWIDTH-1:0]   o_port_rdata,
    output logic [2:0]             o_port_rdata_valid,
    output logic [31:0]            o_wb_adr,
    output logic [WB_SWIDTH-1:0]   o_wb_sel,
    output logic                   o_wb_we,
    output logic [WB_DWIDTH-1:0]   o_wb_dat,
    output logic                   o_wb_cyc,
    output logic                   o_wb_stb,
    input  logic [WB_DWIDTH-1:0]   i_wb_dat,
    input  logic                   i_wb_ack,
    input  logic                   i_wb_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WB_WRITE = 2'd1,
        WB_READ  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            adr_q, adr_d;
    logic [WB_SWIDTH-1:0]   sel_q, sel_d;
    logic                   we_q, we_d;
    logic [WB_DWIDTH-1:0]   dat_q, dat_d;
    logic                   cyc_q, cyc_d;
    logic [1:0]             gnt_q, gnt_d;
    logic [WB_DWIDTH-1:0]   rdata_q, rdata_d;
    logic [2:0]             rdata_valid_q, rdata_valid_d;

    // Unpacked per-port views; entry 3 is a zero filler so a 2-bit index
    // can never select an undriven element.
    logic [31:0]            port_addr  [0:3];
    logic [WB_SWIDTH-1:0]   port_be    [0:3];
    logic [WB_DWIDTH-1:0]   port_wdata [0:3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_port
        assign port_addr[gi]  = i_port_addr[32*gi +: 32];
        assign port_be[gi]    = i_port_be[WB_SWIDTH*gi +: WB_SWIDTH];
        assign port_wdata[gi] = i_port_wdata[WB_DWIDTH*gi +: WB_DWIDTH];
    end
    assign port_addr[3]  = '0;
    assign port_be[3]    = '0;
    assign port_wdata[3] = '0;

    logic       grant_any;
    logic [1:0] grant_idx;

    assign grant_any = |i_port_valid;

`ifdef A25_WB_ARB_RR_EN
    logic [1:0] last_q, last_d;
    logic [1:0] ord0, ord1, ord2;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Search order starts just after the most recently granted port.
    assign ord0 = next_port(last_q);
    assign ord1 = next_port(ord0);
    assign ord2 = next_port(ord1);

    always_comb begin
        if (i_port_valid[ord0])      grant_idx = ord0;
        else if (i_port_valid[ord1]) grant_idx = ord1;
        else                         grant_idx = ord2;
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && grant_any)
            last_d = grant_idx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) last_q <= 2'd2;
        else       last_q <= last_d;
    end
`else
    always_comb begin
        if (i_port_valid[0])      grant_idx = 2'd0;
        else if (i_port_valid[1]) grant_idx = 2'd1;
        else                      grant_idx = 2'd2;
    end
`endif

    // Accept is combinational so the port buffer sees it in the request cycle.
    assign o_port_accepted = (state_q == IDLE && grant_any) ? (3'b001 << grant_idx) : 3'b000;

    always_comb begin
        state_d       = state_q;
        adr_d         = adr_q;
        sel_d         = sel_q;
        we_d          = we_q;
        dat_d         = dat_q;
        cyc_d         = cyc_q;
        gnt_d         = gnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 3'b000;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    adr_d   = port_addr[grant_idx];
                    sel_d   = port_be[grant_idx];
                    we_d    = i_port_write[grant_idx];
                    dat_d   = port_wdata[grant_idx];
                    cyc_d   = 1'b1;
                    gnt_d   = grant_idx;
                    state_d = i_port_write[grant_idx] ? WB_WRITE : WB_READ;
                end
            end
            WB_WRITE: begin
                // Port buffer has already acked the core; nothing to return.
                if (i_wb_ack || i_wb_err) begin
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            WB_READ: begin
                if (i_wb_ack || i_wb_err) begin
                    // Error wins over ack and returns zeroed data.
                    rdata_d       = i_wb_err ? '0 : i_wb_dat;
                    rdata_valid_d = 3'b001 << gnt_q;
                    cyc_d         = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            adr_q         <= '0;
            sel_q         <= '0;
            we_q          <= 1'b0;
            dat_q         <= '0;
            cyc_q         <= 1'b0;
            gnt_q         <= 2'd0;
            rdata_q       <= '0;
            rdata_valid_q <= 3'b000;
        end else begin
            state_q       <= state_d;
            adr_q         <= adr_d;
            sel_q         <= sel_d;
            we_q          <= we_d;
            dat_q         <= dat_d;
            cyc_q         <= cyc_d;
            gnt_q         <= gnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign o_wb_adr           = adr_q;
    assign o_wb_sel           = sel_q;
    assign o_wb_we            = we_q;
    assign o_wb_dat           = dat_q;
    assign o_wb_cyc           = cyc_q;
    assign o_wb_stb           = cyc_q;
    assign o_port_rdata       = rdata_q;
    assign o_port_rdata_valid = rdata_valid_q;

endmodule

// File: doc/a25_wishbone_arb.md
# a25_wishbone_arb

Wishbone bus arbiter and cycle sequencer for the Amber core's 128-bit wishbone master interface. It takes the three buffered ports: instruction cache reads, cached data accesses and uncached data accesses. It grants one port at a time and runs a single classic (non-pipelined) wishbone cycle for that port. For reads it returns the captured data to the granted port. It sits between the three port buffers and the external wishbone bus.

## Interface
Parameters:
- WB_DWIDTH, 128, wishbone data width in bits; fixed at 128.
- WB_SWIDTH, 16, byte-select width; must equal WB_DWIDTH/8.

Ports:
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_port_valid  input  3  request valid per port; bit 0 = icache, bit 1 = dcache cached, bit 2 = dcache uncached.
- o_port_accepted  output  3  one-cycle pulse telling a port that its request was captured; one-hot or zero.
- i_port_write  input  3  per-port write flag.
- i_port_wdata  input  3*128  per-port write data; port n occupies bits [128n+127:128n].
- i_port_be  input  3*16  per-port byte enables.
- i_port_addr  input  3*32  per-port byte address.
- o_port_rdata  output  128  read data shared by all ports; valid only with o_port_rdata_valid.
- o_port_rdata_valid  output  3  one-cycle pulse to the port whose read completed; one-hot or zero.
- o_wb_adr  output  32  wishbone address.
- o_wb_sel  output  16  wishbone byte select.
- o_wb_we  output  1  wishbone write enable.
- o_wb_dat  output  128  wishbone write data.
- o_wb_cyc  output  1  wishbone cycle.
- o_wb_stb  output  1  wishbone strobe; always equal to o_wb_cyc.
- i_wb_dat  input  128  wishbone read data.
- i_wb_ack  input  1  wishbone acknowledge.
- i_wb_err  input  1  wishbone error.

## Operation
- The state machine has three states: IDLE, WB_WRITE and WB_READ.
- IDLE, when any i_port_valid bit is set:
  - Select the grant index g using the arbitration rule below.
  - Pulse o_port_accepted[g] combinationally in that same cycle.
  - Register the port's addr, be, wdata and write flag onto the o_wb_* outputs.
  - Set o_wb_cyc and o_wb_stb.
  - Go to WB_WRITE if the write flag is 1, otherwise WB_READ.
- WB_WRITE, on i_wb_ack or i_wb_err: clear cyc/stb and go to IDLE. There is no response pulse, because the port buffer already acked the core.
- WB_READ, on i_wb_ack or i_wb_err:
  - Register i_wb_dat into o_port_rdata. Register zero instead if i_wb_err was set.
  - Pulse o_port_rdata_valid[g] in the next cycle.
  - Clear cyc/stb and go to IDLE.
- If i_wb_ack and i_wb_err are both set, the cycle is treated as an error.
- In IDLE, ack and err are ignored.
- o_wb_adr, o_wb_sel, o_wb_we and o_wb_dat hold their values for the whole cycle. They change only when a grant is made.
- Arbitration without the macro: fixed priority, port 0 > port 1 > port 2.
- Reset values: state IDLE; o_wb_cyc, o_wb_stb, o_wb_we = 0; o_wb_adr, o_wb_dat = 0; o_wb_sel = 16'h0000; o_port_rdata = 0; o_port_rdata_valid = 0; last-grant pointer = 2. With the pointer at 2, port 0 is first after reset.
- Reset asserted mid-cycle: cyc and stb drop asynchronously and the transaction is abandoned. No accepted or rdata_valid pulse is issued for it.

## Timing
- Grant latency: the o_port_accepted pulse comes in the same cycle T as valid (IDLE only). o_wb_cyc is high from T+1.
- Minimum wishbone cycle is 1 clock: ack at T+1 drops cyc at T+2.
- Read return: ack sampled at cycle A gives o_port_rdata_valid and o_port_rdata at A+1.
- Back-to-back: the next grant can occur at A+1 (IDLE), with the next cyc at A+2. The bus is idle for at least one cycle between transactions.
- o_port_accepted never pulses while cyc is high. At most one bit of o_port_accepted is set in any cycle, and likewise for o_port_rdata_valid.

## Configuration
- A25_WB_ARB_RR_EN defined: round-robin arbitration.
  - Priority starts at the port after the last granted port, wrapping 2 -> 0.
  - The pointer updates on every grant.
  - Under continuous requests from all ports, grants follow 0,1,2,0,…
- A25_WB_ARB_RR_EN undefined: fixed priority, 0 > 1 > 2. The pointer logic is not built.

## Test plan
- Read by port 1 alone, addr 32'h0000_1000, ack 2 cycles after cyc rises, i_wb_dat = 128'hA5…A5 -> accepted[1] in the request cycle; cyc high for 3 cycles; rdata_valid = 3'b010 one cycle after ack with rdata = 128'hA5…A5.
- Write by port 2, be = 16'h00F0, wdata = 128'h1234…, immediate ack -> o_wb_we = 1, o_wb_sel = 16'h00F0, cyc high for 1 cycle, no rdata_valid pulse.
- All three ports valid continuously, each acked in 1 cycle -> fixed build grants 0,0,0…; with A25_WB_ARB_RR_EN grants 0,1,2,0 with one idle bus cycle between transactions.
- Read with i_wb_err = 1 and i_wb_dat = all ones -> rdata_valid pulses with o_port_rdata = 0; state returns to IDLE.
- i_rst asserted while cyc is high in WB_READ -> cyc, stb and we drop without waiting for a clock edge, no rdata_valid pulse; after release the next port 0 request is granted normally.
